issue_sched: RTL and testbench
==============================

Name: issue_sched

Overview:
- Issue scheduler between the reservation station and the functional units.
- Each cycle it picks at most one ready, not-yet-issued RS entry per FU class (ALU, LOAD, STORE, MULT), using round-robin within the class.
- It tracks FU occupancy for the non-pipelined classes and holds an issued mask until the RS frees the entry on CDB broadcast.
- Its outputs drive the fu_in_packet issue_valid and fu_id selection into execute.

Parameters:
NUM_RS, 6, number of RS entries; vector bit i corresponds to RS entry i+1
NUM_CLASS, 4, FU classes: 0=ALU 1=LOAD 2=STORE 3=MULT
MULT_LAT, 4, MULT occupancy in cycles, range 2..15
IDX_W, 3, width of an entry index

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
squash  in  1  synchronous flush
ready_vec  in  NUM_RS  entry is valid and both operands are valid
entry_fu  in  NUM_RS*2  FU class of each entry (static)
free_vec  in  NUM_RS  entry freed by CDB this cycle
fu_done  in  NUM_CLASS  completion pulse from LOAD/STORE units; bits 0 and 3 are ignored
issue_valid  out  NUM_CLASS  registered one-cycle issue pulse per class
issue_idx  out  NUM_CLASS*IDX_W  issued entry number (1..NUM_RS), 0 when not valid
fu_busy  out  NUM_CLASS  class occupied
issued_mask  out  NUM_RS  entry issued and awaiting free

Behaviour:
- Reset (reset==0, asynchronous):
  - issue_valid=0, issue_idx=0, fu_busy=0, issued_mask=0, MULT counter=0.
  - All class FSMs go to IDLE.
  - Round-robin pointers are set to NUM_RS-1, so the first search starts at bit 0.
- Eligibility in cycle t: ready_vec[i] & ~issued_mask[i] & ~free_vec[i] & (entry_fu[i]==c) & ~fu_busy[c].
- Selection:
  - First eligible bit, scanning upward from ptr[c]+1 with wrap modulo NUM_RS.
  - On a grant, ptr[c] becomes the granted bit.
  - Classes are independent; up to 4 issues per cycle.
- Latency: grant is registered. issue_valid/issue_idx are visible at t+1 and held for exactly one cycle. issued_mask[i] sets at t+1.
- issued_mask[i]:
  - Clears on free_vec[i] (visible next cycle).
  - If free and grant target the same bit in the same cycle, the grant is suppressed by the eligibility rule.
- Class FSM, states IDLE and BUSY:
  - ALU: always IDLE (pipelined); fu_busy[0] stays 0, so one ALU issue is possible per cycle.
  - MULT:
    - On issue at T, enter BUSY with counter=MULT_LAT-1; fu_busy[3]=1 for cycles T..T+MULT_LAT-1.
    - Counter decrements each cycle; at 0 the FSM returns to IDLE.
    - Earliest next MULT decision is at T+MULT_LAT, so the next issue is visible at T+MULT_LAT+1.
  - LOAD/STORE:
    - On issue at T, enter BUSY; fu_busy stays 1 until fu_done[c] is sampled high, then IDLE the next cycle.
    - fu_done sampled in the same cycle T as the issue ends BUSY at T+1.
    - fu_done while IDLE is ignored.
- Squash (synchronous, when reset==1):
  - Next cycle: issue_valid=0, issue_idx=0, issued_mask=0, all FSMs IDLE, fu_busy=0, counter=0.
  - Pointers are preserved.
  - Grants computed in the squash cycle are discarded.
- Reset mid-BUSY: immediate return to the reset values above.
- entry_fu values outside 0..3 can never match a class; such entries are never issued.

Decomposition:
- The shared sys_defs package holds:
  - FU_CLASS enum (ALU, LOAD, STORE, MULT), reused from the RS entry fu field.
  - `NUM_RS, `RS_TAG_WIDTH.
  - An ISSUE_PACKET struct {valid, idx} per class.
- One sub-module, rr_pick:
  - Parameterized NUM_RS-wide combinational round-robin picker.
  - Inputs: request vector, pointer. Outputs: one-hot grant, index, any.
  - Instantiated once per class.
- Class FSM and counter stay in issue_sched.

Test Plan:
1. Reset release, ready_vec=6'b000011 (entries 1 and 2, ALU) -> cycle 1: issue_valid[0]=1, idx=1. Cycle 2: idx=2. issued_mask=6'b000011.
2. MULT entries 5 and 6 ready, MULT_LAT=4 -> idx=5 issued at T; fu_busy[3]=1 for T..T+3; idx=6 issued at T+5.
3. LOAD entry 3 issued at T, fu_done[1] held 0 for 10 cycles -> fu_busy[1] stays 1. fu_done[1]=1 at T+10 -> fu_busy[1]=0 at T+11.
4. Entry 1 issued, then free_vec=6'b000001 at T+3 with ready still 1 -> issued_mask[0] clears at T+4; reissue of idx=1 at T+5.
5. Squash while MULT is BUSY and entries 1, 3 and 5 are in issued_mask -> next cycle: all outputs 0. With ALU ready on entries 1 and 2 (last grant was entry 1), the next grant is entry 2 (pointer preserved).
6. reset driven to 0 asynchronously mid-cycle during LOAD BUSY -> fu_busy and issued_mask read 0 before the next clock edge.

Source files
------------

// File: rtl/issue_sched_pkg.sv
// ---------------------------------------------------------------------------
// issue_sched_pkg
// Shared definitions for the issue scheduler slice:
//   - FU class encoding (matches the RS entry fu field)
//   - default RS sizing and entry-tag width
//   - per-class scheduler state and the registered issue packet
// ---------------------------------------------------------------------------
package issue_sched_pkg;

    localparam int SYS_NUM_RS    = 6;
    localparam int RS_TAG_WIDTH  = 3;
    localparam int SYS_NUM_CLASS = 4;

    typedef enum logic [1:0] {
        FU_ALU   = 2'd0,
        FU_LOAD  = 2'd1,
        FU_STORE = 2'd2,
        FU_MULT  = 2'd3
    } fu_class_e;

    typedef enum logic {
        CLS_IDLE = 1'b0,
        CLS_BUSY = 1'b1
    } class_state_e;

    // idx is the 1-based RS entry number, 0 when valid is low
    typedef struct packed {
        logic                    valid;
        logic [RS_TAG_WIDTH-1:0] idx;
    } issue_packet_t;

endpackage

// File: rtl/issue_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker over an NUM_RS-wide request vector.
// The search starts at bit ptr+1 and wraps modulo NUM_RS, so the bit
// named by ptr has the lowest priority.
// Ports:
//   req   - request vector
//   ptr   - bit index of the previous grant
//   grant - one-hot grant (all zero when nothing requests)
//   index - bit index of the granted request
//   any   - at least one request was granted
// ---------------------------------------------------------------------------
module rr_pick
    import issue_sched_pkg::*;
#(
    parameter int NUM_RS = SYS_NUM_RS,
    parameter int IDX_W  = RS_TAG_WIDTH
) (
    input  logic [NUM_RS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_RS-1:0] grant,
    output logic [IDX_W-1:0]  index,
    output logic              any
);

    // Walk the offsets 1..NUM_RS from the pointer; the first hit wins.
    always_comb begin
        int pos;
        grant = '0;
        index = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 1; k <= NUM_RS; k++) begin
            pos = (int'(ptr) + k) % NUM_RS;
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                index      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/issue_sched.sv
// ---------------------------------------------------------------------------
// issue_sched
// Picks at most one ready, not-yet-issued RS entry per FU class each cycle
// (round-robin within the class), registers the pick as a one-cycle issue
// pulse, tracks occupancy of the non-pipelined units and keeps an issued
// mask until the RS frees the entry.
// Ports:
//   clock       - system clock
//   reset       - asynchronous reset, active low
//   squash      - synchronous flush of issue state (pointers kept)
//   ready_vec   - entry valid with both operands ready (bit i = entry i+1)
//   entry_fu    - 2-bit FU class per entry
//   free_vec    - entry freed by CDB this cycle
//   fu_done     - completion pulse from LOAD (bit 1) and STORE (bit 2)
//   issue_valid - registered issue pulse per class
//   issue_idx   - issued entry number per class, 0 when not valid
//   fu_busy     - class occupied
//   issued_mask - entry issued and awaiting free
// ---------------------------------------------------------------------------
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int NUM_RS    = SYS_NUM_RS,
    parameter int NUM_CLASS = SYS_NUM_CLASS,
    parameter int MULT_LAT  = 4,
    parameter int IDX_W     = RS_TAG_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic [NUM_RS-1:0]          ready_vec,
    input  logic [NUM_RS*2-1:0]        entry_fu,
    input  logic [NUM_RS-1:0]          free_vec,
    input  logic [NUM_CLASS-1:0]       fu_done,
    output logic [NUM_CLASS-1:0]       issue_valid,
    output logic [NUM_CLASS*IDX_W-1:0] issue_idx,
    output logic [NUM_CLASS-1:0]       fu_busy,
    output logic [NUM_RS-1:0]          issued_mask
);

    localparam int CNT_W = 4;

    logic [NUM_RS-1:0]    req       [NUM_CLASS];
    logic [NUM_RS-1:0]    grant     [NUM_CLASS];
    logic [IDX_W-1:0]     pick_idx  [NUM_CLASS];
    logic [NUM_CLASS-1:0] pick_any;
    logic [NUM_RS-1:0]    grant_all;

    issue_packet_t        pkt_q     [NUM_CLASS];
    logic [IDX_W-1:0]     ptr_q     [NUM_CLASS];
    logic [NUM_RS-1:0]    mask_q;

    class_state_e         state_q   [NUM_CLASS];
    class_state_e         state_d   [NUM_CLASS];
    logic [CNT_W-1:0]     mult_cnt_q;
    logic [CNT_W-1:0]     mult_cnt_d;

    // An entry requests its class only when it is ready, not already in
    // flight, not being freed this very cycle, and the unit can accept it.
    always_comb begin
        for (int c = 0; c < NUM_CLASS; c++) begin
            req[c] = '0;
            for (int i = 0; i < NUM_RS; i++) begin
                req[c][i] = ready_vec[i] & ~mask_q[i] & ~free_vec[i]
                          & (entry_fu[2*i +: 2] == 2'(c)) & ~fu_busy[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CLASS; c++) begin : g_pick
        rr_pick #(
            .NUM_RS (NUM_RS),
            .IDX_W  (IDX_W)
        ) u_pick (
            .req    (req[c]),
            .ptr    (ptr_q[c]),
            .grant  (grant[c]),
            .index  (pick_idx[c]),
            .any    (pick_any[c])
        );
    end

    always_comb begin
        grant_all = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            grant_all = grant_all | grant[c];
        end
    end

    // Issue packets, round-robin pointers and the issued mask. A squash
    // drops this cycle's grants and leaves the pointers untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                pkt_q[c] <= '0;
                ptr_q[c] <= IDX_W'(NUM_RS - 1);
            end
            mask_q <= '0;
        end else if (squash) begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                pkt_q[c] <= '0;
            end
            mask_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                pkt_q[c].valid <= pick_any[c];
                pkt_q[c].idx   <= pick_any[c] ? RS_TAG_WIDTH'(pick_idx[c] + 1'b1) : '0;
                if (pick_any[c]) begin
                    ptr_q[c] <= pick_idx[c];
                end
            end
            mask_q <= (mask_q & ~free_vec) | grant_all;
        end
    end

    // Class FSM state register and MULT occupancy counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                state_q[c] <= CLS_IDLE;
            end
            mult_cnt_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                state_q[c] <= state_d[c];
            end
            mult_cnt_q <= mult_cnt_d;
        end
    end

    // ALU is pipelined and never leaves IDLE. MULT stays busy for MULT_LAT
    // cycles counted down from the issue cycle; LOAD/STORE wait for fu_done.
    always_comb begin
        mult_cnt_d = mult_cnt_q;
        for (int c = 0; c < NUM_CLASS; c++) begin
            state_d[c] = state_q[c];
            if (c != int'(FU_ALU)) begin
                case (state_q[c])
                    CLS_IDLE: begin
                        if (pick_any[c]) begin
                            state_d[c] = CLS_BUSY;
                            if (c == int'(FU_MULT)) begin
                                mult_cnt_d = CNT_W'(MULT_LAT - 1);
                            end
                        end
                    end
                    CLS_BUSY: begin
                        if (c == int'(FU_MULT)) begin
                            if (mult_cnt_q == '0) begin
                                state_d[c] = CLS_IDLE;
                            end else begin
                                mult_cnt_d = mult_cnt_q - 1'b1;
                            end
                        end else if (fu_done[c]) begin
                            state_d[c] = CLS_IDLE;
                        end
                    end
                    default: state_d[c] = CLS_IDLE;
                endcase
            end
        end
        if (squash) begin
            for (int c = 0; c < NUM_CLASS; c++) begin
                state_d[c] = CLS_IDLE;
            end
            mult_cnt_d = '0;
        end
    end

    always_comb begin
        issue_valid = '0;
        issue_idx   = '0;
        fu_busy     = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            issue_valid[c]              = pkt_q[c].valid;
            issue_idx[c*IDX_W +: IDX_W] = IDX_W'(pkt_q[c].idx);
            fu_busy[c]                  = (state_q[c] == CLS_BUSY);
        end
    end

    assign issued_mask = mask_q;

endmodule

// File: tb/tb_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_issue_sched
// Directed bench for issue_sched: a table of single-cycle vectors for the
// basic pick/mask behaviour, then hand-written sequences for MULT latency,
// LOAD completion, free/reissue, squash and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_issue_sched;

    logic        clock;
    logic        reset;
    logic        squash;
    logic [5:0]  ready_vec;
    logic [11:0] entry_fu;
    logic [5:0]  free_vec;
    logic [3:0]  fu_done;
    logic [3:0]  issue_valid;
    logic [11:0] issue_idx;
    logic [3:0]  fu_busy;
    logic [5:0]  issued_mask;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [5:0]  ready;
        logic [11:0] fu;
        logic [5:0]  free;
        logic [3:0]  done;
        logic        sq;
        logic [3:0]  exp_valid;
        logic [11:0] exp_idx;
        logic [3:0]  exp_busy;
        logic [5:0]  exp_mask;
    } vec_t;

    vec_t vecs [11];

    issue_sched #(
        .NUM_RS    (6),
        .NUM_CLASS (4),
        .MULT_LAT  (4),
        .IDX_W     (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .ready_vec   (ready_vec),
        .entry_fu    (entry_fu),
        .free_vec    (free_vec),
        .fu_done     (fu_done),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .fu_busy     (fu_busy),
        .issued_mask (issued_mask)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [5:0] r, input logic [11:0] f,
                                  input logic [5:0] fr, input logic [3:0] d, input logic sq);
        ready_vec = r;
        entry_fu  = f;
        free_vec  = fr;
        fu_done   = d;
        squash    = sq;
    endtask

    task automatic check_output(input string tag, input logic [3:0] v, input logic [11:0] idx,
                                input logic [3:0] b, input logic [5:0] m);
        check({tag, " issue_valid"}, 32'(issue_valid), 32'(v));
        check({tag, " issue_idx"},   32'(issue_idx),   32'(idx));
        check({tag, " fu_busy"},     32'(fu_busy),     32'(b));
        check({tag, " issued_mask"}, 32'(issued_mask), 32'(m));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        apply_stimulus(6'b0, 12'h000, 6'b0, 4'b0, 1'b0);

        // ready, fu, free, done, squash | valid, idx, busy, mask
        vecs[0]  = '{6'b000011, 12'h000, 6'b000000, 4'b0000, 1'b0, 4'b0001, 12'h001, 4'b0000, 6'b000001};
        vecs[1]  = '{6'b000011, 12'h000, 6'b000000, 4'b0000, 1'b0, 4'b0001, 12'h002, 4'b0000, 6'b000011};
        vecs[2]  = '{6'b000011, 12'h000, 6'b000000, 4'b0000, 1'b0, 4'b0000, 12'h000, 4'b0000, 6'b000011};
        vecs[3]  = '{6'b000011, 12'h000, 6'b000011, 4'b0000, 1'b0, 4'b0000, 12'h000, 4'b0000, 6'b000000};
        vecs[4]  = '{6'b000011, 12'h000, 6'b000000, 4'b0000, 1'b0, 4'b0001, 12'h001, 4'b0000, 6'b000001};
        vecs[5]  = '{6'b000011, 12'h000, 6'b000001, 4'b0000, 1'b0, 4'b0001, 12'h002, 4'b0000, 6'b000010};
        vecs[6]  = '{6'b000000, 12'h000, 6'b000010, 4'b0000, 1'b0, 4'b0000, 12'h000, 4'b0000, 6'b000000};
        vecs[7]  = '{6'b001111, 12'h024, 6'b000000, 4'b0000, 1'b0, 4'b0111, 12'h0D4, 4'b0110, 6'b001110};
        vecs[8]  = '{6'b001111, 12'h024, 6'b000000, 4'b0110, 1'b0, 4'b0001, 12'h001, 4'b0000, 6'b001111};
        vecs[9]  = '{6'b001111, 12'h024, 6'b000000, 4'b1111, 1'b0, 4'b0000, 12'h000, 4'b0000, 6'b001111};
        vecs[10] = '{6'b000000, 12'h024, 6'b001111, 4'b0000, 1'b0, 4'b0000, 12'h000, 4'b0000, 6'b000000};

        // Reset state
        #2 reset = 1'b0;
        #3;
        check_output("reset", 4'b0, 12'h000, 4'b0, 6'b0);
        step();
        step();
        reset = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].ready, vecs[i].fu, vecs[i].free, vecs[i].done, vecs[i].sq);
            step();
            check_output($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx,
                         vecs[i].exp_busy, vecs[i].exp_mask);
        end

        // MULT entries 5 and 6: busy for four cycles, next issue at T+5
        apply_stimulus(6'b110000, 12'hF00, 6'b0, 4'b0, 1'b0);
        step();
        check_output("mult_issue", 4'b1000, 12'hA00, 4'b1000, 6'b010000);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("mult_busy_t%0d", k), 32'(fu_busy), (k < 4) ? 32'h8 : 32'h0);
            check($sformatf("mult_valid_t%0d", k), 32'(issue_valid), 32'h0);
        end
        step();
        check_output("mult_reissue", 4'b1000, 12'hC00, 4'b1000, 6'b110000);
        apply_stimulus(6'b0, 12'hF00, 6'b110000, 4'b0, 1'b0);
        step();
        apply_stimulus(6'b0, 12'hF00, 6'b0, 4'b0, 1'b0);
        step();
        step();
        step();
        check("mult_idle fu_busy", 32'(fu_busy), 32'h0);
        check("mult_idle issued_mask", 32'(issued_mask), 32'h0);

        // LOAD entry 3 held busy until fu_done
        apply_stimulus(6'b000100, 12'h010, 6'b0, 4'b0, 1'b0);
        step();
        check_output("load_issue", 4'b0010, 12'h018, 4'b0010, 6'b000100);
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("load_busy_t%0d", k), 32'(fu_busy), 32'h2);
            if (k == 10) begin
                apply_stimulus(6'b000100, 12'h010, 6'b0, 4'b0010, 1'b0);
            end
        end
        step();
        check("load_release fu_busy", 32'(fu_busy), 32'h0);
        apply_stimulus(6'b0, 12'h010, 6'b000100, 4'b0, 1'b0);
        step();
        check("load_freed issued_mask", 32'(issued_mask), 32'h0);
        apply_stimulus(6'b0, 12'h000, 6'b0, 4'b0, 1'b0);

        // ALU entry 1 freed at T+3, reissued at T+5
        apply_stimulus(6'b000001, 12'h000, 6'b0, 4'b0, 1'b0);
        step();
        check_output("alu_issue", 4'b0001, 12'h001, 4'b0, 6'b000001);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("alu_hold_mask_t%0d", k), 32'(issued_mask), 32'h01);
            check($sformatf("alu_hold_valid_t%0d", k), 32'(issue_valid), 32'h0);
        end
        apply_stimulus(6'b000001, 12'h000, 6'b000001, 4'b0, 1'b0);
        step();
        check("alu_free issued_mask", 32'(issued_mask), 32'h0);
        check("alu_free issue_valid", 32'(issue_valid), 32'h0);
        apply_stimulus(6'b000001, 12'h000, 6'b0, 4'b0, 1'b0);
        step();
        check_output("alu_reissue", 4'b0001, 12'h001, 4'b0, 6'b000001);

        // Squash with MULT busy and entries 1, 3, 5 in flight
        apply_stimulus(6'b010101, 12'h310, 6'b0, 4'b0, 1'b0);
        step();
        check_output("pre_squash", 4'b1010, 12'hA18, 4'b1010, 6'b010101);
        apply_stimulus(6'b000011, 12'h310, 6'b0, 4'b0, 1'b1);
        step();
        check_output("squash", 4'b0, 12'h000, 4'b0, 6'b0);
        apply_stimulus(6'b000011, 12'h310, 6'b0, 4'b0, 1'b0);
        step();
        check_output("post_squash", 4'b0001, 12'h002, 4'b0, 6'b000010);

        // Asynchronous reset in the middle of a LOAD busy period
        apply_stimulus(6'b000100, 12'h310, 6'b0, 4'b0, 1'b0);
        step();
        check_output("load_busy", 4'b0010, 12'h018, 4'b0010, 6'b000110);
        #3 reset = 1'b0;
        #1;
        check_output("async_reset", 4'b0, 12'h000, 4'b0, 6'b0);
        step();
        reset = 1'b1;
        apply_stimulus(6'b000011, 12'h000, 6'b0, 4'b0, 1'b0);
        step();
        check_output("after_reset", 4'b0001, 12'h001, 4'b0, 6'b000001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
